// File: rtl/target_arbiter_pkg.sv
// Shared types and widths for the two-initiator target arbiter.
package target_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rw;
    } req_t;

endpackage

// File: rtl/target_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant moves only when a grant is consumed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        // NOTE: default first so every path assigns o_grant and no latch is inferred.
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/target_arbiter.sv
// Round-robin sharing of one memory target between two requesters, with
// one-cycle address/data strobes, ack timeout and per-requester completion.
module target_arbiter
    import target_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_rw,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_done,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_rw,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_done,
    output logic              req1_err,
    output logic [ADDR_W-1:0] tgt_addr_out,
    output logic              tgt_addr_out_valid,
    output logic [DATA_W-1:0] tgt_data_out,
    output logic              tgt_data_out_valid,
    output logic              tgt_rw,
    input  logic [DATA_W-1:0] tgt_data_in,
    input  logic              tgt_data_in_valid,
    input  logic              tgt_ack,
    input  logic              tgt_ready
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    req_t              r_req;
    logic              r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [1:0]        w_grant;
    logic              w_handshake;
    logic              w_timeout;
    req_t              w_sel_req;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({req1_valid, req0_valid}),
        .i_advance (w_handshake),
        .o_grant   (w_grant)
    );

    // Grant already implies valid; rst_n gating keeps ready low during reset.
    assign w_handshake = rst_n && (r_state == IDLE) && (|w_grant);
    assign req0_ready  = w_handshake && w_grant[0];
    assign req1_ready  = w_handshake && w_grant[1];
    assign w_sel_req   = w_grant[1] ? {req1_addr, req1_wdata, req1_rw}
                                    : {req0_addr, req0_wdata, req0_rw};
    assign w_timeout   = (r_cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_handshake)          w_next_state = ISSUE;
            ISSUE:   if (tgt_ready)            w_next_state = WAIT;
            WAIT:    if (tgt_ack || w_timeout) w_next_state = RESP;
            RESP:                              w_next_state = IDLE;
            default:                           w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req              <= '0;
            r_owner            <= 1'b0;
            r_cnt              <= '0;
            r_rdata            <= '0;
            r_err              <= 1'b0;
            tgt_addr_out       <= '0;
            tgt_addr_out_valid <= 1'b0;
            tgt_data_out       <= '0;
            tgt_data_out_valid <= 1'b0;
            tgt_rw             <= 1'b0;
            req0_rdata         <= '0;
            req0_done          <= 1'b0;
            req0_err           <= 1'b0;
            req1_rdata         <= '0;
            req1_done          <= 1'b0;
            req1_err           <= 1'b0;
        end else begin
            tgt_addr_out_valid <= 1'b0;
            tgt_data_out_valid <= 1'b0;
            req0_done          <= 1'b0;
            req0_err           <= 1'b0;
            req1_done          <= 1'b0;
            req1_err           <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_owner <= w_grant[1];
                        r_req   <= w_sel_req;
                    end
                end
                ISSUE: begin
                    if (tgt_ready) begin
                        tgt_addr_out       <= r_req.addr;
                        tgt_data_out       <= r_req.wdata;
                        tgt_rw             <= r_req.rw;
                        tgt_addr_out_valid <= 1'b1;
                        tgt_data_out_valid <= r_req.rw;
                        r_cnt              <= '0;
                    end
                end
                WAIT: begin
                    // An ack on the final counted cycle still completes cleanly.
                    if (tgt_ack) begin
                        r_err   <= 1'b0;
                        r_rdata <= (!r_req.rw && tgt_data_in_valid) ? tgt_data_in : '0;
                    end else begin
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                RESP: begin
                    if (r_owner) begin
                        req1_done  <= 1'b1;
                        req1_err   <= r_err;
                        req1_rdata <= r_rdata;
                    end else begin
                        req0_done  <= 1'b1;
                        req0_err   <= r_err;
                        req0_rdata <= r_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_target_arbiter.sv
// Randomized transaction-level bench for target_arbiter with a timeline and memory model.
module tb_target_arbiter;
    import target_arb_pkg::*;

    localparam int TO = 15;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_addr, req1_addr;
    logic [7:0]  req0_wdata, req1_wdata;
    logic        req0_rw, req1_rw;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_rdata, req1_rdata;
    logic        req0_done, req1_done, req0_err, req1_err;
    logic [15:0] tgt_addr_out;
    logic        tgt_addr_out_valid;
    logic [7:0]  tgt_data_out;
    logic        tgt_data_out_valid;
    logic        tgt_rw;
    logic [7:0]  tgt_data_in;
    logic        tgt_data_in_valid, tgt_ack, tgt_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         m_last;
    logic [7:0] m_rdata [2];
    bit         m_known [2];
    logic [7:0] mem [logic [15:0]];

    target_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rw(req0_rw),
        .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rw(req1_rw),
        .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_done(req1_done), .req1_err(req1_err),
        .tgt_addr_out(tgt_addr_out), .tgt_addr_out_valid(tgt_addr_out_valid),
        .tgt_data_out(tgt_data_out), .tgt_data_out_valid(tgt_data_out_valid), .tgt_rw(tgt_rw),
        .tgt_data_in(tgt_data_in), .tgt_data_in_valid(tgt_data_in_valid),
        .tgt_ack(tgt_ack), .tgt_ready(tgt_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {tgt_addr_out, tgt_addr_out_valid, tgt_data_out, tgt_data_out_valid, tgt_rw,
                    req0_ready, req0_rdata, req0_done, req0_err,
                    req1_ready, req1_rdata, req1_done, req1_err}, 64'd0);
    endtask

    task automatic model_reset();
        m_last     = 1'b1;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        m_known[0] = 1'b1;
        m_known[1] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req0_valid        = 1'b0;
            req1_valid        = 1'b0;
            tgt_ack           = 1'(($urandom_range(0, 1)));
            tgt_data_in_valid = 1'(($urandom_range(0, 1)));
            tgt_data_in       = 8'($urandom);
            #1;
            check("idle_ready", {req1_ready, req0_ready}, 0);
            @(posedge clk);
            @(negedge clk);
            check("idle_done", {req1_done, req0_done}, 0);
        end
    endtask

    // One complete transaction: d cycles of tgt_ready=0, ack on WAIT cycle lat
    // (lat=0 or >TO means no ack), dv_ok=0 drops read-data valid on the ack.
    task automatic run_txn(input bit v0, input bit v1, input req_t q0, input req_t q1,
                           input int d, input int lat, input bit dv_ok, input bit drop);
        int         own;
        int         n_wait;
        bit         exp_err;
        logic [7:0] exp_rd;
        logic [7:0] tgt_val;
        req_t       q;

        own = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
        q   = (own == 1) ? q1 : q0;
        req0_valid = v0; req0_addr = q0.addr; req0_wdata = q0.wdata; req0_rw = q0.rw;
        req1_valid = v1; req1_addr = q1.addr; req1_wdata = q1.wdata; req1_rw = q1.rw;
        tgt_ready         = 1'(($urandom_range(0, 1)));
        tgt_ack           = 1'(($urandom_range(0, 1)));
        tgt_data_in_valid = 1'(($urandom_range(0, 1)));
        tgt_data_in       = 8'($urandom);
        #1;
        check("ready0", req0_ready, own == 0);
        check("ready1", req1_ready, own == 1);
        m_last = (own == 1);
        @(posedge clk);
        @(negedge clk);
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end

        for (int i = 0; i <= d; i++) begin
            check("issue_ready", {req1_ready, req0_ready}, 0);
            check("issue_strobe", {tgt_addr_out_valid, tgt_data_out_valid}, 0);
            check("issue_done", {req1_done, req0_done}, 0);
            tgt_ready         = (i == d);
            tgt_ack           = 1'(($urandom_range(0, 1)));
            tgt_data_in_valid = 1'(($urandom_range(0, 1)));
            tgt_data_in       = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
        end

        check("addr_valid", tgt_addr_out_valid, 1);
        check("tgt_addr", tgt_addr_out, q.addr);
        check("tgt_rw", tgt_rw, q.rw);
        check("data_valid", tgt_data_out_valid, q.rw);
        if (q.rw) check("tgt_data", tgt_data_out, q.wdata);

        n_wait  = (lat >= 1 && lat <= TO) ? lat : TO;
        exp_err = (n_wait != lat);
        tgt_val = mem.exists(q.addr) ? mem[q.addr] : 8'h00;
        exp_rd  = (!q.rw && !exp_err && dv_ok) ? tgt_val : 8'h00;

        for (int w = 1; w <= n_wait; w++) begin
            if (w > 1) check("wait_strobe", {tgt_addr_out_valid, tgt_data_out_valid}, 0);
            check("wait_ready", {req1_ready, req0_ready}, 0);
            check("wait_done", {req1_done, req0_done}, 0);
            tgt_ready = 1'(($urandom_range(0, 1)));
            tgt_ack   = (w == lat);
            if (w == lat) begin
                tgt_data_in_valid = dv_ok;
                tgt_data_in       = dv_ok ? tgt_val : 8'($urandom);
            end else begin
                tgt_data_in_valid = 1'(($urandom_range(0, 1)));
                tgt_data_in       = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end

        check("resp_done", {req1_done, req0_done}, 0);
        tgt_ack           = 1'(($urandom_range(0, 1)));
        tgt_data_in_valid = 1'(($urandom_range(0, 1)));
        tgt_data_in       = 8'($urandom);
        @(posedge clk);
        @(negedge clk);

        check("done_own", (own == 1) ? req1_done : req0_done, 1);
        check("done_other", (own == 1) ? req0_done : req1_done, 0);
        check("err", (own == 1) ? req1_err : req0_err, exp_err);
        if (!q.rw || exp_err) begin
            m_rdata[own] = exp_rd;
            m_known[own] = 1'b1;
            check("rdata_own", (own == 1) ? req1_rdata : req0_rdata, exp_rd);
        end else begin
            m_known[own] = 1'b0;
        end
        if (m_known[1-own]) check("rdata_hold", (own == 1) ? req0_rdata : req1_rdata, m_rdata[1-own]);
        if (q.rw && !exp_err) mem[q.addr] = q.wdata;
        tgt_ack           = 1'b0;
        tgt_data_in_valid = 1'b0;
    endtask

    task automatic reset_mid();
        req0_valid = 1'b1; req0_addr = 16'h1234; req0_wdata = 8'h5A; req0_rw = 1'b1;
        req1_valid = 1'b0;
        tgt_ready  = 1'b1;
        tgt_ack    = 1'b0;
        tgt_data_in_valid = 1'b0;
        #1;
        check("rst_mid_ready", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_strobe", {tgt_addr_out_valid, tgt_addr_out}, {1'b1, 16'h1234});
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tgt_ack = 1'b1; tgt_data_in_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tgt_ack = 1'b0; tgt_data_in_valid = 1'b0;
        model_reset();
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   v0, v1;
        req_t q0, q1;
        int   d, lat;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = '0; req0_wdata = '0; req0_rw = 1'b0;
        req1_valid = 1'b1; req1_addr = '0; req1_wdata = '0; req1_rw = 1'b0;
        tgt_data_in = '0; tgt_data_in_valid = 1'b0; tgt_ack = 1'b0; tgt_ready = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        run_txn(1, 0, '{addr: 16'h0003, wdata: 8'hA5, rw: 1'b1}, '0, 0, 1, 1, 0);
        run_txn(0, 1, '0, '{addr: 16'h0003, wdata: 8'h00, rw: 1'b0}, 0, 1, 1, 0);
        for (int k = 0; k < 4; k++)
            run_txn(1, 1, '{addr: 16'h0010, wdata: 8'(k), rw: 1'b1},
                          '{addr: 16'h0003, wdata: 8'h00, rw: 1'b0}, 0, 1, 1, 0);
        run_txn(1, 0, '{addr: 16'h0004, wdata: 8'h3C, rw: 1'b1}, '0, 3, 1, 1, 1);
        run_txn(1, 0, '{addr: 16'h0003, wdata: 8'h00, rw: 1'b0}, '0, 0, 0, 1, 0);
        run_txn(0, 1, '0, '{addr: 16'h0004, wdata: 8'h00, rw: 1'b0}, 1, TO, 1, 0);
        run_txn(0, 1, '0, '{addr: 16'h0004, wdata: 8'h00, rw: 1'b0}, 0, 2, 0, 0);
        reset_mid();
        run_txn(1, 1, '{addr: 16'h0005, wdata: 8'h77, rw: 1'b1},
                      '{addr: 16'h0006, wdata: 8'h88, rw: 1'b1}, 0, 1, 1, 0);

        for (int k = 0; k < 40; k++) begin
            v0 = 1'(($urandom_range(0, 1)));
            v1 = v0 ? 1'(($urandom_range(0, 1))) : 1'b1;
            q0 = '{addr: 16'($urandom_range(0, 7)), wdata: 8'($urandom), rw: 1'(($urandom_range(0, 1)))};
            q1 = '{addr: 16'($urandom_range(0, 7)), wdata: 8'($urandom), rw: 1'(($urandom_range(0, 1)))};
            d  = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0:       lat = 0;
                1:       lat = TO + 1;
                2:       lat = TO;
                default: lat = $urandom_range(1, 4);
            endcase
            run_txn(v0, v1, q0, q1, d, lat, $urandom_range(0, 3) != 0, 1'(($urandom_range(0, 1))));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
